sm_bus_arbiter: RTL and testbench

//  Shares the single system data bus (address decoder + RAM/GPIO/PWM/ALS slaves) among N bus masters,
//  e.g. the CPU data port and a DMA/debug master. Round-robin arbitration, one transaction at a time,

---
 rtl/sm_bus_arbiter_pkg.sv | 19 +
 rtl/sm_bus_arbiter_if.sv | 32 +++
 rtl/sm_bus_arbiter_picker.sv | 29 ++
 rtl/sm_bus_arbiter.sv | 78 +++++++
 tb/tb_sm_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sm_bus_arbiter_pkg.sv
// Shared types and defaults for the system bus arbiter.
// Holds the state encoding, default master count and an index-width helper.
package sm_bus_arbiter_pkg;

  localparam int ARB_N_MASTERS = 2;
  localparam int ARB_DW        = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_DONE
  } arb_state_t;

  // Width of a master index; the arbiter supports 2..4 masters.
  function automatic int arb_idx_w(input int n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/sm_bus_arbiter_if.sv
// Master-side request bundle plus the single shared bus toward the matrix.
// The master modport is the environment (masters and matrix); slave is the arbiter.
interface sm_bus_arbiter_if
  import sm_bus_arbiter_pkg::*;
#(
  parameter int N  = ARB_N_MASTERS,
  parameter int DW = ARB_DW
);

  logic [N-1:0]    mReq;
  logic [N-1:0]    mLock;
  logic [N-1:0]    mWrite;
  logic [N*DW-1:0] mAddr;
  logic [N*DW-1:0] mWData;
  logic [N*DW-1:0] mRData;
  logic [N-1:0]    mAck;
  logic [DW-1:0]   bAddr;
  logic            bWrite;
  logic [DW-1:0]   bWData;
  logic [DW-1:0]   bRData;

  modport master (
    output mReq, mLock, mWrite, mAddr, mWData, bRData,
    input  mRData, mAck, bAddr, bWrite, bWData
  );

  modport slave (
    input  mReq, mLock, mWrite, mAddr, mWData, bRData,
    output mRData, mAck, bAddr, bWrite, bWData
  );

endinterface

// File: rtl/sm_bus_arbiter_picker.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module sm_arb_rr_picker
  import sm_bus_arbiter_pkg::*;
#(
  parameter int N  = ARB_N_MASTERS,
  parameter int IW = arb_idx_w(ARB_N_MASTERS)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] winner
);

  int idx;

  // Scan from the farthest offset down so the nearest requester overwrites the result.
  always_comb begin
    valid  = |req;
    winner = '0;
    idx    = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        winner = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/sm_bus_arbiter.sv
// Round-robin arbiter sharing one data bus among N masters, one transaction per three cycles.
module sm_bus_arbiter
  import sm_bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = ARB_N_MASTERS,
  parameter int DW        = ARB_DW
) (
  input logic             clk,
  input logic             rst_n,
  sm_bus_arbiter_if.slave bus
);

  localparam int IW = arb_idx_w(N_MASTERS);

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] winner;
  logic          valid;

  sm_arb_rr_picker #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_picker (
    .req    (bus.mReq),
    .ptr    (ptr),
    .valid  (valid),
    .winner (winner)
  );

  // bAddr/bWData double as the capture registers; bWrite is cleared on leaving ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      ptr        <= '0;
      owner      <= '0;
      bus.bAddr  <= '0;
      bus.bWData <= '0;
      bus.bWrite <= 1'b0;
      bus.mAck   <= '0;
      bus.mRData <= '0;
    end else begin
      bus.mAck <= '0;
      case (state)
        ARB_IDLE: begin
          if (valid) begin
            owner      <= winner;
            bus.bAddr  <= bus.mAddr[winner*DW +: DW];
            bus.bWData <= bus.mWData[winner*DW +: DW];
            bus.bWrite <= bus.mWrite[winner];
            state      <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          bus.mRData[owner*DW +: DW] <= bus.bRData;
          bus.mAck[owner]            <= 1'b1;
          bus.bWrite                 <= 1'b0;
          state                      <= ARB_DONE;
        end
        ARB_DONE: begin
          // A locked owner keeps the pointer so it wins the next round again.
          if (bus.mLock[owner]) begin
            ptr <= owner;
          end else if (owner == IW'(N_MASTERS - 1)) begin
            ptr <= '0;
          end else begin
            ptr <= owner + 1'b1;
          end
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_bus_arbiter.sv
// Directed bench for sm_bus_arbiter with a small RAM/GPIO/PWM/ALS bus-matrix model.
module tb_sm_bus_arbiter;
  import sm_bus_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int DW = 32;

  localparam logic [31:0] GPIO_ADDR = 32'h0000_7f00;
  localparam logic [31:0] PWM_ADDR  = 32'h0000_7f10;
  localparam logic [31:0] ALS_ADDR  = 32'h0000_7f20;
  localparam logic [31:0] ALS_VAL   = 32'h0000_0abc;
  localparam logic [31:0] PWM_INIT  = 32'h0000_00aa;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sm_bus_arbiter_if #(.N(N), .DW(DW)) bus ();

  sm_bus_arbiter #(.N_MASTERS(N), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] ram [0:63];
  logic [31:0] gpio = 32'h0;
  logic [31:0] pwm  = PWM_INIT;

  // Bus matrix: read data is combinational in bAddr, peripheral writes land on the clock edge.
  always_comb begin
    bus.bRData = 32'h0;
    if (bus.bAddr == GPIO_ADDR)     bus.bRData = gpio;
    else if (bus.bAddr == PWM_ADDR) bus.bRData = pwm;
    else if (bus.bAddr == ALS_ADDR) bus.bRData = ALS_VAL;
    else if (bus.bAddr < 32'h100)   bus.bRData = ram[bus.bAddr[7:2]];
  end

  always @(posedge clk) begin
    if (bus.bWrite) begin
      if (bus.bAddr == GPIO_ADDR)     gpio <= bus.bWData;
      else if (bus.bAddr == PWM_ADDR) pwm  <= bus.bWData;
    end
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic req, input logic wr, input logic lock,
                               input logic [31:0] addr, input logic [31:0] data);
    bus.mReq[idx]            = req;
    bus.mWrite[idx]          = wr;
    bus.mLock[idx]           = lock;
    bus.mAddr[idx*32 +: 32]  = addr;
    bus.mWData[idx*32 +: 32] = data;
  endtask

  task automatic waitAck(input int idx, input int limit, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.mAck[idx] !== 1'b1 && lat < limit);
    if (bus.mAck[idx] !== 1'b1) lat = -1;
  endtask

  // Monitor: write cycles, grant order and ack timestamps, plus the one-hot ack rule.
  int          wr_cycles = 0;
  int          last_wr_cyc = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;
  int          ack_count = 0;
  int          grant_log [$];
  int          ack_cyc [$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.bWrite) begin
        wr_cycles++;
        last_wr_cyc  = cyc;
        last_wr_addr = bus.bAddr;
        last_wr_data = bus.bWData;
      end
      if (bus.mAck != '0) begin
        ack_count++;
        checkOutput("ack_onehot", $countones(bus.mAck), 1);
        grant_log.push_back(bus.mAck[1] ? 1 : 0);
        ack_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int lat;
    int wr_base;
    int ack_base;
    int g0;

    for (int i = 0; i < 64; i++) ram[i] = 32'h1000_0000 + i;
    ram[4] = 32'hcafe_0001;
    ram[5] = 32'hbeef_0005;
    bus.mReq   = '0;
    bus.mLock  = '0;
    bus.mWrite = '0;
    bus.mAddr  = '0;
    bus.mWData = '0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_mAck", bus.mAck, 0);
    checkOutput("rst_bWrite", bus.bWrite, 0);
    checkOutput("rst_bAddr", bus.bAddr, 0);
    checkOutput("rst_bWData", bus.bWData, 0);
    checkOutput("rst_mRData0", bus.mRData[31:0], 0);
    checkOutput("rst_mRData1", bus.mRData[63:32], 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single read by m0");
    wr_base  = wr_cycles;
    ack_base = ack_count;
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    waitAck(0, 10, lat);
    checkOutput("t1_latency", lat, 2);
    checkOutput("t1_mAck", bus.mAck, 32'h1);
    checkOutput("t1_rdata", bus.mRData[31:0], 32'hcafe_0001);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    repeat (4) @(negedge clk);
    checkOutput("t1_no_write", wr_cycles - wr_base, 0);
    checkOutput("t1_one_ack", ack_count - ack_base, 1);

    $display("[TB] single write by m1");
    wr_base = wr_cycles;
    applyStimulus(1, 1'b1, 1'b1, 1'b0, GPIO_ADDR, 32'h55);
    waitAck(1, 10, lat);
    checkOutput("t2_latency", lat, 2);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("t2_write_cycles", wr_cycles - wr_base, 1);
    checkOutput("t2_write_addr", last_wr_addr, GPIO_ADDR);
    checkOutput("t2_write_data", last_wr_data, 32'h55);
    checkOutput("t2_ack_after_write", ack_cyc[$] - last_wr_cyc, 1);
    checkOutput("t2_gpio", gpio, 32'h55);
    repeat (2) @(negedge clk);

    $display("[TB] contention, both held");
    g0 = grant_log.size();
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
    repeat (12) @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("t3_grants", grant_log.size() - g0, 4);
    for (int k = 0; k < 4 && g0 + k < grant_log.size(); k++)
      checkOutput($sformatf("t3_order%0d", k), grant_log[g0+k], k % 2);
    for (int k = 0; k < 3 && g0 + k + 1 < ack_cyc.size(); k++)
      checkOutput($sformatf("t3_spacing%0d", k), ack_cyc[g0+k+1] - ack_cyc[g0+k], 3);
    checkOutput("t3_rdata1", bus.mRData[63:32], 32'hbeef_0005);

    $display("[TB] lock held by m0");
    g0 = grant_log.size();
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
    repeat (8) @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    repeat (3) @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("t4_grants", grant_log.size() - g0, 4);
    for (int k = 0; k < 4 && g0 + k < grant_log.size(); k++)
      checkOutput($sformatf("t4_order%0d", k), grant_log[g0+k], (k == 3) ? 1 : 0);

    $display("[TB] reset during a write access");
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    waitAck(0, 10, lat);
    checkOutput("t5_pre_latency", lat, 2);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, PWM_ADDR, 32'h1234);
    @(posedge clk);
    #1;
    checkOutput("t5_bWrite_access", bus.bWrite, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_bWrite_async", bus.bWrite, 0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("t5_pwm", pwm, PWM_INIT);
    checkOutput("t5_no_ack", bus.mAck, 0);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
    waitAck(0, 10, lat);
    checkOutput("t5_post_latency", lat, 2);
    checkOutput("t5_post_mAck", bus.mAck, 32'h1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("t5_rdata0", bus.mRData[31:0], 32'hcafe_0001);

    $display("[TB] request withdrawn during access");
    wr_base  = wr_cycles;
    ack_base = ack_count;
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    waitAck(1, 10, lat);
    checkOutput("t6_latency", lat, 1);
    repeat (6) @(negedge clk);
    checkOutput("t6_single_ack", ack_count - ack_base, 1);
    checkOutput("t6_no_write", wr_cycles - wr_base, 0);
    checkOutput("t6_rdata1", bus.mRData[63:32], 32'hbeef_0005);
    checkOutput("t6_rdata0_kept", bus.mRData[31:0], 32'hcafe_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
